// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that lets two local requesters share a
// single 8-bit APB slave. Each granted request runs through the APB SETUP and
// ACCESS phases, and its result (read data, slave error or timeout) goes back
// to the requester that owns the transfer. Only one transfer is in flight.
module apb_req_arbiter #(
  parameter int unsigned TIMEOUT = 15  // ACCESS cycles without pready before abort; 0 = never
) (
  input  logic        clk,
  input  logic        presetn,
  // local requesters
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  // APB master side
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [7:0]  pwdata,
  input  logic [7:0]  prdata,
  input  logic        pready,
  input  logic        pslverr
);

  // Counter value one below the limit: the abort fires on the pready-low edge
  // that would make the counter reach TIMEOUT.
  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);
  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_reg, state_next;

  logic        psel_reg, psel_next;
  logic        penable_reg, penable_next;
  logic        pwrite_reg, pwrite_next;
  logic [7:0]  paddr_reg, paddr_next;
  logic [7:0]  pwdata_reg, pwdata_next;
  logic [1:0]  req_ack_reg, req_ack_next;
  logic [1:0]  rsp_valid_reg, rsp_valid_next;
  logic [7:0]  rsp_rdata_reg, rsp_rdata_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        owner_reg, owner_next;
  logic        last_grant_reg, last_grant_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;

  // Per-requester views of the packed request buses
  logic [7:0]  req_addr_arr  [2];
  logic [7:0]  req_wdata_arr [2];
  logic [1:0]  win_onehot;
  logic [1:0]  owner_onehot;

  logic        any_req;
  logic        win;
  logic        timeout_hit;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_addr_arr[gi]  = req_addr[8*gi +: 8];
      assign req_wdata_arr[gi] = req_wdata[8*gi +: 8];
      assign win_onehot[gi]    = (win == 1'(gi));
      assign owner_onehot[gi]  = (owner_reg == 1'(gi));
    end
  endgenerate

  assign timeout_hit = TIMEOUT_EN && (wait_cnt_reg == TIMEOUT_M1);

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not granted last
  always_comb begin
    any_req = |req_valid;
    if (req_valid == 2'b11) begin
      win = ~last_grant_reg;
    end else begin
      win = req_valid[1];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic; pready takes priority over a coincident timeout
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (pready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output logic: next values of every registered output and datapath register
  always_comb begin
    psel_next       = (state_next != IDLE);
    penable_next    = (state_next == ACCESS);
    pwrite_next     = pwrite_reg;
    paddr_next      = paddr_reg;
    pwdata_next     = pwdata_reg;
    req_ack_next    = 2'b00;
    rsp_valid_next  = 2'b00;
    rsp_rdata_next  = rsp_rdata_reg;
    rsp_err_next    = rsp_err_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    wait_cnt_next   = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          pwrite_next     = req_write[win];
          paddr_next      = req_addr_arr[win];
          pwdata_next     = req_wdata_arr[win];
          req_ack_next    = win_onehot;
          owner_next      = win;
          last_grant_next = win;
          wait_cnt_next   = 8'd0;
        end
      end
      SETUP: begin
        wait_cnt_next = wait_cnt_reg;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_next = owner_onehot;
          rsp_err_next   = pslverr;
          rsp_rdata_next = pwrite_reg ? 8'h00 : prdata;
          wait_cnt_next  = 8'd0;
        end else if (timeout_hit) begin
          rsp_valid_next = owner_onehot;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = 8'h00;
          wait_cnt_next  = 8'd0;
        end else begin
          wait_cnt_next  = wait_cnt_reg + 8'd1;
        end
      end
      default: begin
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // Output and datapath registers; reset drops the bus and cancels any transfer
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      psel_reg       <= 1'b0;
      penable_reg    <= 1'b0;
      pwrite_reg     <= 1'b0;
      paddr_reg      <= 8'h00;
      pwdata_reg     <= 8'h00;
      req_ack_reg    <= 2'b00;
      rsp_valid_reg  <= 2'b00;
      rsp_rdata_reg  <= 8'h00;
      rsp_err_reg    <= 1'b0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      wait_cnt_reg   <= 8'd0;
    end else begin
      psel_reg       <= psel_next;
      penable_reg    <= penable_next;
      pwrite_reg     <= pwrite_next;
      paddr_reg      <= paddr_next;
      pwdata_reg     <= pwdata_next;
      req_ack_reg    <= req_ack_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_rdata_reg  <= rsp_rdata_next;
      rsp_err_reg    <= rsp_err_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      wait_cnt_reg   <= wait_cnt_next;
    end
  end

  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign req_ack   = req_ack_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Testbench for apb_req_arbiter: an APB slave model with per-transfer wait
// states and error injection, plus a reference model of grant order, timing
// and response contents derived from the arbiter's rules.
module tb_apb_req_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        presetn;
  logic [1:0]  req_valid, req_write;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_ack, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem     [256];  // slave storage, written only by bus transfers
  logic [7:0] ref_mem [256];  // expected slave contents, written only by the model
  int         model_last;

  typedef struct {
    logic [1:0] ack_vec;
    int         ack_k;
    int         ack_count;
    int         psel_cycles;
    int         pen_cycles;
    bit         setup_bad;
    bit         unstable;
    logic [1:0] rsp_vec;
    int         rsp_k;
    int         rsp_count;
    logic [7:0] rdata;
    logic       err;
    logic       psel_at_rsp;
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
  } obs_t;

  always #5 clk = ~clk;

  apb_req_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // Reference arbitration rule: lone requester wins, tie goes to the one not granted last
  function automatic int pick(logic [1:0] v);
    if (v == 2'b11) return 1 - model_last;
    return v[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    presetn = 1'b0;
    req_valid = 2'b00; req_write = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    presetn = 1'b1;
    model_last = 1;
  endtask

  // Drives one arbitration round and plays the slave; records what the DUT did.
  // All requesters withdraw once any ack is seen, so exactly one transfer runs.
  task automatic run_xfer(input logic [1:0] vpat, input logic [1:0] wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input int waits, input bit slverr,
                          output obs_t o);
    int k, acc_n, post;
    bit have_bus;
    o.ack_vec = 2'b00; o.ack_k = 0; o.ack_count = 0; o.psel_cycles = 0; o.pen_cycles = 0;
    o.setup_bad = 0; o.unstable = 0; o.rsp_vec = 2'b00; o.rsp_k = 0; o.rsp_count = 0;
    o.rdata = 8'h00; o.err = 1'b0; o.psel_at_rsp = 1'b0; o.addr = 8'h00; o.wr = 1'b0; o.wdata = 8'h00;
    @(negedge clk);
    req_valid = vpat; req_write = wr; req_addr = addr; req_wdata = wdata;
    pready = 1'b0; pslverr = 1'b0;
    k = 0; acc_n = 0; post = -1; have_bus = 0;
    while (k < 300 && post != 0) begin
      @(posedge clk); #1; k++;
      if (req_ack != 2'b00) begin
        o.ack_count++;
        if (o.ack_vec == 2'b00) begin o.ack_vec = req_ack; o.ack_k = k; end
        req_valid = 2'b00;
      end
      if (psel) begin
        o.psel_cycles++;
        if (!have_bus) begin
          have_bus = 1; o.addr = paddr; o.wr = pwrite; o.wdata = pwdata;
          if (penable) o.setup_bad = 1;
        end else if (paddr !== o.addr || pwrite !== o.wr || pwdata !== o.wdata) begin
          o.unstable = 1;
        end
      end
      if (penable) o.pen_cycles++;
      if (rsp_valid != 2'b00) begin
        o.rsp_count++;
        if (o.rsp_vec == 2'b00) begin
          o.rsp_vec = rsp_valid; o.rsp_k = k; o.rdata = rsp_rdata; o.err = rsp_err; o.psel_at_rsp = psel;
        end
        if (post < 0) post = 2;
      end else if (post > 0) begin
        post--;
      end
      // Slave: hold pready low for 'waits' ACCESS cycles, then complete
      if (psel && penable) begin
        acc_n++;
        if (acc_n > waits) begin
          pready = 1'b1; pslverr = slverr; prdata = mem[paddr];
          if (pwrite && !slverr) mem[paddr] = pwdata;
        end else begin
          pready = 1'b0; pslverr = 1'b0;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    $display("xfer: ack=%b addr=%02h wr=%0d wdata=%02h rsp=%b rdata=%02h err=%0d rsp_cycle=%0d",
             o.ack_vec, o.addr, o.wr, o.wdata, o.rsp_vec, o.rdata, o.err, o.rsp_k);
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    req_valid = 2'b00; req_write = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    @(posedge clk); #1;
    checks++; if ({psel, penable, pwrite} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got %b expected 000", {psel, penable, pwrite}); end
    checks++; if ({paddr, pwdata} !== 16'h0000) begin failures++; $display("FAIL reset_bus: got %h expected 0000", {paddr, pwdata}); end
    checks++; if ({req_ack, rsp_valid} !== 4'b0000) begin failures++; $display("FAIL reset_pulses: got %b expected 0000", {req_ack, rsp_valid}); end
    checks++; if ({rsp_rdata, rsp_err} !== 9'h000) begin failures++; $display("FAIL reset_rsp: got %h expected 000", {rsp_rdata, rsp_err}); end
    @(negedge clk); presetn = 1'b1; model_last = 1;
    repeat (2) @(posedge clk); #1;
    checks++; if ({psel, req_ack} !== 3'b000) begin failures++; $display("FAIL idle_no_req: got %b expected 000", {psel, req_ack}); end
  endtask

  task automatic test_single_read();
    obs_t o;
    mem[8'h20] = 8'hA5; ref_mem[8'h20] = 8'hA5;
    model_last = 0;  // requester 0 granted
    run_xfer(2'b01, 2'b00, 16'h0020, 16'h0000, 0, 1'b0, o);
    checks++; if (o.ack_vec !== 2'b01 || o.ack_k != 1 || o.ack_count != 1) begin failures++; $display("FAIL rd_ack: got %b@%0d x%0d expected 01@1 x1", o.ack_vec, o.ack_k, o.ack_count); end
    checks++; if (o.psel_cycles != 2 || o.pen_cycles != 1 || o.setup_bad) begin failures++; $display("FAIL rd_phases: got psel=%0d pen=%0d setup_bad=%0d expected 2 1 0", o.psel_cycles, o.pen_cycles, o.setup_bad); end
    checks++; if (o.addr !== 8'h20 || o.wr !== 1'b0) begin failures++; $display("FAIL rd_bus: got %h/%b expected 20/0", o.addr, o.wr); end
    checks++; if (o.rsp_vec !== 2'b01 || o.rsp_k != 3 || o.psel_at_rsp !== 1'b0) begin failures++; $display("FAIL rd_rsp: got %b@%0d psel=%b expected 01@3 psel=0", o.rsp_vec, o.rsp_k, o.psel_at_rsp); end
    checks++; if (o.rdata !== 8'hA5 || o.err !== 1'b0) begin failures++; $display("FAIL rd_data: got %h err=%b expected a5 err=0", o.rdata, o.err); end
  endtask

  task automatic test_wait_states();
    obs_t o;
    model_last = 1;
    run_xfer(2'b10, 2'b10, 16'h1000, 16'h3C00, 4, 1'b0, o);
    ref_mem[8'h10] = 8'h3C;
    checks++; if (o.ack_vec !== 2'b10) begin failures++; $display("FAIL ws_ack: got %b expected 10", o.ack_vec); end
    checks++; if (o.addr !== 8'h10 || o.wr !== 1'b1 || o.wdata !== 8'h3C || o.unstable) begin failures++; $display("FAIL ws_bus: got %h/%b/%h unstable=%0d expected 10/1/3c 0", o.addr, o.wr, o.wdata, o.unstable); end
    checks++; if (o.rsp_vec !== 2'b10 || o.rsp_count != 1 || o.rsp_k != 7) begin failures++; $display("FAIL ws_rsp: got %b x%0d @%0d expected 10 x1 @7", o.rsp_vec, o.rsp_count, o.rsp_k); end
    checks++; if (o.err !== 1'b0 || o.rdata !== 8'h00 || o.psel_cycles != 6) begin failures++; $display("FAIL ws_status: got err=%b rdata=%h psel=%0d expected 0 00 6", o.err, o.rdata, o.psel_cycles); end
    model_last = 1;
    run_xfer(2'b10, 2'b00, 16'h1000, 16'h0000, 1, 1'b0, o);
    checks++; if (o.rdata !== ref_mem[8'h10] || o.rsp_vec !== 2'b10) begin failures++; $display("FAIL ws_readback: got %h rsp=%b expected %h rsp=10", o.rdata, o.rsp_vec, ref_mem[8'h10]); end
  endtask

  task automatic test_arbitration();
    int got[$];
    int rsps[$];
    int cnt[2];
    int k, last, a0, a1, g;
    bit prev_ack, dbl;
    do_reset();
    cnt[0] = 0; cnt[1] = 0; dbl = 0; prev_ack = 0; k = 0;
    @(negedge clk);
    req_write = 2'b00; req_addr = 16'h0201; req_valid = 2'b11;
    while (k < 200 && rsps.size() < 4) begin
      @(posedge clk); #1; k++;
      if (req_ack != 2'b00) begin
        if (prev_ack) dbl = 1;
        prev_ack = 1;
        for (int i = 0; i < 2; i++) begin
          if (req_ack[i]) begin
            got.push_back(i); cnt[i]++;
            if (cnt[i] >= 2) req_valid[i] = 1'b0;
          end
        end
      end else begin
        prev_ack = 0;
      end
      for (int i = 0; i < 2; i++) if (rsp_valid[i]) rsps.push_back(i);
      pready = psel && penable; pslverr = 1'b0; prdata = mem[paddr];
    end
    pready = 1'b0; req_valid = 2'b00;
    checks++; if (got.size() != 4 || rsps.size() != 4) begin failures++; $display("FAIL arb_count: got acks=%0d rsps=%0d expected 4 4", got.size(), rsps.size()); end
    checks++; if (cnt[0] != 2 || cnt[1] != 2 || dbl) begin failures++; $display("FAIL arb_pulses: got %0d/%0d dbl=%0d expected 2/2 0", cnt[0], cnt[1], dbl); end
    last = 1; a0 = 2; a1 = 2;
    for (int n = 0; n < 4; n++) begin
      if (a0 > 0 && a1 > 0) g = 1 - last; else g = (a0 > 0) ? 0 : 1;
      last = g;
      if (g == 0) a0--; else a1--;
      if (n < got.size() && n < rsps.size()) begin
        checks++; if (got[n] != g || rsps[n] != g) begin failures++; $display("FAIL arb_order[%0d]: got grant=%0d rsp=%0d expected %0d", n, got[n], rsps[n], g); end
      end
    end
    model_last = last;
    $display("xfer: arbitration grants=%p", got);
  endtask

  task automatic test_slave_error();
    obs_t o;
    logic [7:0] exp_d;
    exp_d = ref_mem[8'h55];
    model_last = 0;
    run_xfer(2'b01, 2'b00, 16'h0055, 16'h0000, 2, 1'b1, o);
    checks++; if (o.err !== 1'b1 || o.rsp_vec !== 2'b01 || o.rsp_count != 1) begin failures++; $display("FAIL slverr_rsp: got err=%b %b x%0d expected 1 01 x1", o.err, o.rsp_vec, o.rsp_count); end
    checks++; if (o.rdata !== exp_d || o.psel_at_rsp !== 1'b0) begin failures++; $display("FAIL slverr_data: got %h psel=%b expected %h psel=0", o.rdata, o.psel_at_rsp, exp_d); end
    model_last = 1;
    run_xfer(2'b10, 2'b00, 16'h5500, 16'h0000, 0, 1'b0, o);
    checks++; if (o.ack_k != 1 || o.err !== 1'b0 || o.rdata !== exp_d) begin failures++; $display("FAIL slverr_next: got ack@%0d err=%b %h expected @1 0 %h", o.ack_k, o.err, o.rdata, exp_d); end
  endtask

  task automatic test_timeout();
    obs_t o;
    model_last = 0;
    run_xfer(2'b01, 2'b00, 16'h0020, 16'h0000, 40, 1'b0, o);
    checks++; if (o.err !== 1'b1 || o.rdata !== 8'h00 || o.rsp_vec !== 2'b01) begin failures++; $display("FAIL to_rsp: got err=%b %h %b expected 1 00 01", o.err, o.rdata, o.rsp_vec); end
    checks++; if (o.rsp_k != 2 + TO || o.pen_cycles != TO || o.psel_at_rsp !== 1'b0) begin failures++; $display("FAIL to_timing: got @%0d pen=%0d psel=%b expected @%0d %0d 0", o.rsp_k, o.pen_cycles, o.psel_at_rsp, 2 + TO, TO); end
    model_last = 0;
    run_xfer(2'b01, 2'b00, 16'h0020, 16'h0000, TO - 1, 1'b0, o);
    checks++; if (o.err !== 1'b0 || o.rdata !== ref_mem[8'h20] || o.rsp_k != 2 + TO) begin failures++; $display("FAIL to_edge: got err=%b %h @%0d expected 0 %h @%0d", o.err, o.rdata, o.rsp_k, ref_mem[8'h20], 2 + TO); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int k;
    bit seen, leaked;
    do_reset();
    @(negedge clk);
    req_valid = 2'b01; req_write = 2'b00; req_addr = 16'h0044; pready = 1'b0;
    k = 0; seen = 0;
    while (k < 20 && !seen) begin
      @(posedge clk); #1; k++;
      if (req_ack != 2'b00) req_valid = 2'b00;
      if (penable) seen = 1;
    end
    req_valid = 2'b00;
    checks++; if (!seen) begin failures++; $display("FAIL rst_mid_access: got no ACCESS in 20 cycles expected ACCESS"); end
    #2; presetn = 1'b0; #1;
    checks++; if ({psel, penable, req_ack, rsp_valid} !== 6'b0) begin failures++; $display("FAIL rst_mid_async: got %b expected 000000", {psel, penable, req_ack, rsp_valid}); end
    checks++; if (paddr !== 8'h00) begin failures++; $display("FAIL rst_mid_addr: got %h expected 00", paddr); end
    leaked = 0;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid != 2'b00 || psel) leaked = 1; end
    checks++; if (leaked) begin failures++; $display("FAIL rst_mid_hold: got activity during reset expected none"); end
    @(negedge clk); presetn = 1'b1; model_last = 1;
    model_last = 0;
    run_xfer(2'b01, 2'b00, 16'h0044, 16'h0000, 1, 1'b0, o);
    checks++; if (o.rsp_vec !== 2'b01 || o.err !== 1'b0 || o.rdata !== ref_mem[8'h44]) begin failures++; $display("FAIL rst_mid_after: got %b err=%b %h expected 01 0 %h", o.rsp_vec, o.err, o.rdata, ref_mem[8'h44]); end
  endtask

  task automatic test_random();
    obs_t o;
    logic [1:0] vpat, wr, exp_vec;
    logic [15:0] addr, wdata;
    logic [7:0] ea, ed, exp_rdata;
    logic ew, exp_err;
    int waits, win, exp_k, exp_psel;
    bit se, timed;
    for (int n = 0; n < 40; n++) begin
      vpat  = 2'($urandom_range(1, 3));
      wr    = 2'($urandom);
      addr  = 16'($urandom);
      wdata = 16'($urandom);
      waits = int'($urandom_range(0, 20));
      se    = ($urandom_range(0, 4) == 0);
      win   = pick(vpat);
      model_last = win;
      timed = (TO != 0) && (waits >= TO);
      ea = addr[8*win +: 8]; ed = wdata[8*win +: 8]; ew = wr[win];
      exp_vec   = (win == 1) ? 2'b10 : 2'b01;
      exp_rdata = (timed || ew) ? 8'h00 : ref_mem[ea];
      exp_err   = timed ? 1'b1 : se;
      exp_k     = timed ? 2 + TO : 3 + waits;
      exp_psel  = timed ? 1 + TO : 2 + waits;
      if (!timed && ew && !se) ref_mem[ea] = ed;
      run_xfer(vpat, wr, addr, wdata, waits, se, o);
      checks++; if (o.ack_vec !== exp_vec || o.ack_k != 1 || o.ack_count != 1) begin failures++; $display("FAIL rnd%0d_ack: got %b@%0d x%0d expected %b@1 x1", n, o.ack_vec, o.ack_k, o.ack_count, exp_vec); end
      checks++; if (o.addr !== ea || o.wr !== ew || o.wdata !== ed || o.unstable) begin failures++; $display("FAIL rnd%0d_bus: got %h/%b/%h unstable=%0d expected %h/%b/%h 0", n, o.addr, o.wr, o.wdata, o.unstable, ea, ew, ed); end
      checks++; if (o.rsp_vec !== exp_vec || o.rsp_count != 1 || o.rsp_k != exp_k || o.psel_cycles != exp_psel) begin failures++; $display("FAIL rnd%0d_timing: got %b x%0d @%0d psel=%0d expected %b x1 @%0d psel=%0d", n, o.rsp_vec, o.rsp_count, o.rsp_k, o.psel_cycles, exp_vec, exp_k, exp_psel); end
      checks++; if (o.rdata !== exp_rdata || o.err !== exp_err) begin failures++; $display("FAIL rnd%0d_data: got %h err=%b expected %h err=%b", n, o.rdata, o.err, exp_rdata, exp_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    model_last = 1;
    test_reset();
    test_single_read();
    test_wait_states();
    test_arbitration();
    test_slave_error();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
